// File: rtl/fetch_decode_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_decode_queue_if
//
// Bundles the fetch-side push handshake, the decode-side pop handshake, the
// flush request and the occupancy count of the fetch/decode instruction queue.
//
//   inValid   fetch -> queue   fetch presents an instruction
//   inInstr   fetch -> queue   16-bit instruction word
//   inNextPc  fetch -> queue   PC+2 of that instruction
//   inReady   queue -> fetch   queue can accept an entry this cycle
//   outValid  queue -> decode  head entry is valid
//   outInstr  queue -> decode  head instruction (NOP when empty)
//   outNextPc queue -> decode  head PC+2 (zero when empty)
//   outReady  decode -> queue  decode consumes the head entry
//   flush     branch -> queue  discard all entries and any same-cycle push
//   count     queue -> any     number of occupied entries
//
// Modports: master = the fetch/decode/branch side, slave = the queue itself.
// ---------------------------------------------------------------------------
interface fetch_decode_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          inValid;
    logic [15:0]   inInstr;
    logic [15:0]   inNextPc;
    logic          inReady;
    logic          outValid;
    logic [15:0]   outInstr;
    logic [15:0]   outNextPc;
    logic          outReady;
    logic          flush;
    logic [CW-1:0] count;

    modport master (
        output inValid,
        output inInstr,
        output inNextPc,
        input  inReady,
        input  outValid,
        input  outInstr,
        input  outNextPc,
        output outReady,
        output flush,
        input  count
    );

    modport slave (
        input  inValid,
        input  inInstr,
        input  inNextPc,
        output inReady,
        output outValid,
        output outInstr,
        output outNextPc,
        input  outReady,
        input  flush,
        output count
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// ---------------------------------------------------------------------------
// fetch_decode_queue
//
// Instruction queue between fetch and decode of the 16-bit pipeline. Each
// entry is {instr, nextPc}. Fetch pushes and decode pops with valid/ready
// handshakes; a flush empties the queue in one cycle so wrong-path
// instructions never reach decode.
//
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   asynchronous active-low reset, clears all state immediately
//   bus   fetch_decode_queue_if.slave (handshakes, flush, count)
//
// Parameter:
//   DEPTH number of entries, power of two, minimum 2
// ---------------------------------------------------------------------------
module fetch_decode_queue #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    fetch_decode_queue_if.slave     bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [15:0] NOP_INSTR = 16'h0800;

    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_head;

    // Readiness comes from the registered count only, so there is no
    // combinational path from outReady or flush back to fetch. A pop while
    // full therefore frees a slot only from the next cycle on.
    assign w_in_ready  = (r_count != CW'(DEPTH));
    assign w_out_valid = (r_count != '0);

    // Flush suppresses both handshakes in the cycle it is asserted.
    assign w_push = bus.inValid & w_in_ready & ~bus.flush;
    assign w_pop  = w_out_valid & bus.outReady & ~bus.flush;

    // Pointers are PW bits wide and wrap modulo DEPTH naturally; the separate
    // count distinguishes full from empty when the pointers are equal.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order. The storage
    // array is reset here as well because the reset state clears it to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.flush) begin
            // Storage contents are left as-is; only the bookkeeping is cleared.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {bus.inInstr, bus.inNextPc};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is read from storage only; a same-cycle push is never bypassed.
    assign w_head = r_mem[r_rd_ptr];

    assign bus.inReady   = w_in_ready;
    assign bus.outValid  = w_out_valid;
    assign bus.outInstr  = w_out_valid ? w_head[31:16] : NOP_INSTR;
    assign bus.outNextPc = w_out_valid ? w_head[15:0]  : 16'h0000;
    assign bus.count     = r_count;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_queue
//
// Directed bench for fetch_decode_queue (DEPTH = 4). Inputs change 1 time
// unit after a rising edge; outputs are sampled at that same point, i.e.
// after the registered state has settled and well before the next edge.
// ---------------------------------------------------------------------------
module tb_fetch_decode_queue;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fetch_decode_queue_if #(.DEPTH(4)) bus ();

    fetch_decode_queue #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] instr,
                         input logic [15:0] npc, input logic ordy,
                         input logic fl);
        bus.inValid  = v;
        bus.inInstr  = instr;
        bus.inNextPc = npc;
        bus.outReady = ordy;
        bus.flush    = fl;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    // Checks the head and count without popping.
    task automatic expect_head(input string name, input logic [15:0] instr,
                               input logic [15:0] npc, input logic [2:0] cnt);
        n_checks++;
        if (bus.outValid !== 1'b1 || bus.outInstr !== instr ||
            bus.outNextPc !== npc || bus.count !== cnt) begin
            n_fail++;
            $display("FAIL %s: got v=%b instr=%h npc=%h count=%0d, want v=1 instr=%h npc=%h count=%0d",
                     name, bus.outValid, bus.outInstr, bus.outNextPc, bus.count, instr, npc, cnt);
        end
    endtask

    task automatic expect_empty(input string name);
        n_checks++;
        if (bus.outValid !== 1'b0 || bus.outInstr !== 16'h0800 ||
            bus.outNextPc !== 16'h0000 || bus.count !== 3'd0 || bus.inReady !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got v=%b instr=%h npc=%h count=%0d rdy=%b, want v=0 instr=0800 npc=0000 count=0 rdy=1",
                     name, bus.outValid, bus.outInstr, bus.outNextPc, bus.count, bus.inReady);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        #2;
        expect_empty("reset_state");
        tick();
        tick();
        rst = 1'b1;
        expect_empty("after_release");
    endtask

    task automatic test_basic_flow();
        drive(1'b1, 16'h1234, 16'h0002, 1'b0, 1'b0);
        tick();
        idle();
        expect_head("basic_push", 16'h1234, 16'h0002, 3'd1);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        tick();
        idle();
        expect_empty("basic_pop");
    endtask

    task automatic test_fill_full();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'hA000 + 16'(i), 16'h0010 + 16'(2 * i), 1'b0, 1'b0);
            tick();
        end
        idle();
        n_checks++;
        if (bus.count !== 3'd4 || bus.inReady !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state: got count=%0d rdy=%b, want count=4 rdy=0", bus.count, bus.inReady);
        end
        // Fifth push attempt while full must be dropped.
        drive(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
        tick();
        expect_head("full_ignore", 16'hA000, 16'h0010, 3'd4);
        // Pop while full with push held: pop accepted, push not.
        drive(1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
        tick();
        idle();
        expect_head("full_pop", 16'hA001, 16'h0012, 3'd3);
        n_checks++;
        if (bus.inReady !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pop_ready: got rdy=%b, want 1", bus.inReady);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        tick();
        expect_head("full_drain1", 16'hA002, 16'h0014, 3'd2);
        tick();
        expect_head("full_drain2", 16'hA003, 16'h0016, 3'd1);
        tick();
        idle();
        expect_empty("full_drained");
    endtask

    task automatic test_drain_wrap();
        logic [31:0] exp_q[$];
        logic [31:0] e;
        for (int i = 0; i < 6; i++) begin
            logic do_pop;
            do_pop = (i == 2) || (i == 4);
            if (do_pop) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.outValid !== 1'b1 || {bus.outInstr, bus.outNextPc} !== e) begin
                    n_fail++;
                    $display("FAIL wrap_mid_pop%0d: got v=%b %h_%h, want %h_%h",
                             i, bus.outValid, bus.outInstr, bus.outNextPc, e[31:16], e[15:0]);
                end
            end
            drive(1'b1, 16'hB000 + 16'(i), 16'h0100 + 16'(2 * i), do_pop, 1'b0);
            exp_q.push_back({16'hB000 + 16'(i), 16'h0100 + 16'(2 * i)});
            tick();
        end
        idle();
        // Six pushes, two pops: head is entry 2, count 4.
        expect_head("wrap_full", 16'hB002, 16'h0104, 3'd4);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.outValid !== 1'b1 || {bus.outInstr, bus.outNextPc} !== e) begin
                n_fail++;
                $display("FAIL wrap_drain%0d: got v=%b %h_%h, want %h_%h",
                         k, bus.outValid, bus.outInstr, bus.outNextPc, e[31:16], e[15:0]);
            end
            drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
            tick();
        end
        idle();
        expect_empty("wrap_end");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'hC000 + 16'(i), 16'h0200 + 16'(2 * i), 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            expect_head($sformatf("b2b_head%0d", i), 16'hC000 + 16'(i),
                        16'h0200 + 16'(2 * i), 3'd2);
            drive(1'b1, 16'hC000 + 16'(i + 2), 16'h0200 + 16'(2 * (i + 2)), 1'b1, 1'b0);
            tick();
        end
        idle();
        expect_head("b2b_after", 16'hC00A, 16'h0214, 3'd2);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        tick();
        expect_head("b2b_last", 16'hC00B, 16'h0216, 3'd1);
        tick();
        idle();
        expect_empty("b2b_end");
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'hD000 + 16'(i), 16'h0300 + 16'(2 * i), 1'b0, 1'b0);
            tick();
        end
        idle();
        expect_head("flush_pre", 16'hD000, 16'h0300, 3'd3);
        drive(1'b1, 16'hEEEE, 16'h0EEE, 1'b1, 1'b1);
        tick();
        idle();
        expect_empty("flush_post");
        drive(1'b1, 16'h5A5A, 16'h0400, 1'b0, 1'b0);
        tick();
        idle();
        expect_head("flush_repush", 16'h5A5A, 16'h0400, 3'd1);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        tick();
        idle();
        expect_empty("flush_end");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'hF000 + 16'(i), 16'h0500 + 16'(2 * i), 1'b0, 1'b0);
            tick();
        end
        idle();
        expect_head("arst_pre", 16'hF000, 16'h0500, 3'd2);
        #2;
        rst = 1'b0;
        #1;
        // Between edges: outputs must already be in reset state.
        expect_empty("arst_immediate");
        tick();
        rst = 1'b1;
        drive(1'b1, 16'h7777, 16'h0600, 1'b0, 1'b0);
        tick();
        idle();
        expect_head("arst_first_push", 16'h7777, 16'h0600, 3'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_flow();
        test_fill_full();
        test_drain_wrap();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Backstop so the run always ends on its own.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Small instruction queue between the fetch stage and the decode stage of the 16-bit pipeline. Each entry holds a fetched instruction together with its PC+2 value. Fetch pushes entries with a valid/ready handshake and decode pops them the same way. A flush from the branch-resolution logic discards every buffered entry in one cycle so wrong-path instructions never reach decode.

## Interface
Parameters:
- DEPTH, 4, number of entries; must be a power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; asserting low clears all state immediately.
- inValid  input  1  fetch presents a valid instruction this cycle.
- inInstr  input  16  fetched instruction word.
- inNextPc  input  16  PC+2 of the fetched instruction.
- inReady  output  1  queue can accept an entry this cycle.
- outValid  output  1  head entry is valid.
- outInstr  output  16  instruction at head.
- outNextPc  output  16  PC+2 at head.
- outReady  input  1  decode consumes the head entry this cycle.
- flush  input  1  discard all entries and any same-cycle push.
- count  output  log2(DEPTH)+1  number of occupied entries.

## Operation
- Storage is a circular buffer of DEPTH entries, each 32 bits wide ({instr, nextPc}).
- Pointers:
  - Write pointer and read pointer are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - The occupancy counter is separate and is log2(DEPTH)+1 bits wide.
- push = inValid & inReady & ~flush. It writes the entry at the write pointer and increments the write pointer.
- pop = outValid & outReady & ~flush. It advances the read pointer.
- Counter update:
  - push & pop: count is unchanged; both pointers advance.
  - push only: count +1.
  - pop only: count −1.
- flush:
  - On the next edge, write pointer, read pointer and count all go to 0.
  - Any push or pop in the same cycle is ignored.
  - Storage contents need not be cleared.
- inReady = (count != DEPTH). It depends on registered state only, with no combinational path from outReady or flush.
- outValid = (count != 0).
- When outValid=1, outInstr and outNextPc come from the entry at the read pointer.
- When outValid=0, outInstr = 16'h0800 (NOP) and outNextPc = 16'h0000.
- There is no bypass: an entry pushed in cycle N is visible at the output no earlier than cycle N+1.
- If inValid=1 while inReady=0, nothing is written. Fetch must hold its instruction until it sees inReady=1.
- If outReady=1 while outValid=0, it has no effect.

## Timing
- Reset (rst low, asynchronous):
  - Pointers = 0, count = 0.
  - outValid = 0, inReady = 1.
  - outInstr = 16'h0800, outNextPc = 16'h0000.
  - Storage is cleared to 0.
- Reset is released synchronously with respect to operation: the first push can occur on the first rising edge with rst high.
- Latency is 1 cycle from push to outValid when the queue was empty.
- Throughput is 1 push and 1 pop per cycle sustained.
- Full: count=DEPTH, so inReady=0. A pop in that cycle makes inReady=1 in the next cycle; a push in the same cycle as the pop is not accepted.
- Empty: count=0, so outValid=0. A push in that cycle makes outValid=1 in the next cycle.
- Reset mid-operation: all entries are lost, and outputs take their reset values combinationally with rst.
- Flush and reset together: reset dominates; the results are identical.

## Test plan
- Reset then basic flow:
  - Release rst.
  - Push {0x1234, 0x0002} with outReady=0.
  - Next cycle: outValid=1, outInstr=0x1234, outNextPc=0x0002, count=1.
- Fill and full:
  - Push 4 entries with outReady=0.
  - After the 4th edge: count=4, inReady=0.
  - A 5th inValid is ignored, and count stays 4.
- Drain and wrap:
  - Push 6 entries, interleaving 2 pops.
  - Pop all; the output order matches the push order exactly, across pointer wrap.
  - End state: outValid=0, outInstr=0x0800.
- Simultaneous push and pop:
  - With count=2, assert push and pop for 10 cycles.
  - count stays 2 throughout, and outputs advance one entry per cycle in order.
- Flush:
  - With count=3, assert flush together with inValid=1 and outReady=1.
  - Next cycle: count=0, outValid=0, inReady=1, and the flushed-cycle push is absent.
- Async reset mid-stream:
  - With count=2, drive rst low between clock edges.
  - outValid=0 and count=0 immediately, without waiting for a clock edge.
  - After release, the first push appears correctly.
